// File: rtl/debounce_edge_detect_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge_detect_if
// Description : Signal bundle between the resync stage / control logic and
//               the debouncer.
//               master : drives i_signal, i_clear; observes the results.
//               slave  : the debouncer itself.
//   i_signal       synchronised level from the resync stage
//   i_clear        synchronous clear of the glitch counter
//   o_level        debounced level
//   o_rise/o_fall  one-cycle strobes on accepted transitions
//   o_busy         candidate transition being timed
//   o_glitch_count saturating count of aborted candidates
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_edge_detect_if #(
  parameter int unsigned GLITCH_W = 8
);
  logic                i_signal;
  logic                i_clear;
  logic                o_level;
  logic                o_rise;
  logic                o_fall;
  logic                o_busy;
  logic [GLITCH_W-1:0] o_glitch_count;

  modport master (
    output i_signal, i_clear,
    input  o_level, o_rise, o_fall, o_busy, o_glitch_count
  );

  modport slave (
    input  i_signal, i_clear,
    output o_level, o_rise, o_fall, o_busy, o_glitch_count
  );
endinterface
`default_nettype wire

// File: rtl/debounce_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge_detect
// Description : Debounces an already-synchronised level. A new value must be
//               seen for STABLE_CYCLES consecutive cycles before it is
//               accepted; accepted transitions produce one-cycle rise/fall
//               strobes, aborted candidates bump a saturating glitch count.
// Ports       : i_clk    clock (same domain as the resync output)
//               i_rst_n  synchronous active-low reset
//               bus      debounce_edge_detect_if.slave
//                        (i_signal, i_clear -> o_level, o_rise, o_fall,
//                         o_busy, o_glitch_count)
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge_detect #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_VALUE   = 1'b0,
  parameter int unsigned GLITCH_W      = 8
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  debounce_edge_detect_if.slave bus
);

  localparam int unsigned          CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     C_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_ONE  = CNT_W'(1);
  localparam logic [GLITCH_W-1:0]  C_GMAX = '1;

  localparam logic [1:0] S_STABLE    = 2'd0;
  localparam logic [1:0] S_CANDIDATE = 2'd1;

  logic [1:0]          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                level_q,  level_d;
  logic                rise_q,   rise_d;
  logic                fall_q,   fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  logic w_diff;
  logic w_accept;
  logic w_abort;

  assign w_diff = (bus.i_signal != level_q);

  // State register: all outputs come straight from here.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_VALUE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic. The counter holds the number of consecutive differing
  // samples already seen, so the STABLE_CYCLES-th one arrives with
  // cnt_q == STABLE_CYCLES-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_abort  = 1'b0;

    case (state_q)
      S_STABLE: begin
        cnt_d = '0;
        if (w_diff) begin
          if (STABLE_CYCLES == 1) begin
            w_accept = 1'b1;
          end else begin
            state_d = S_CANDIDATE;
            cnt_d   = C_ONE;
          end
        end
      end
      S_CANDIDATE: begin
        if (!w_diff) begin
          w_abort = 1'b1;
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == C_LAST) begin
          w_accept = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_STABLE;
        cnt_d   = '0;
      end
    endcase

    if (w_accept) begin
      state_d = S_STABLE;
      cnt_d   = '0;
    end

    level_d = w_accept ? bus.i_signal : level_q;
    rise_d  = w_accept &  bus.i_signal;
    fall_d  = w_accept & ~bus.i_signal;

    // Clear wins over a coincident abort.
    glitch_d = glitch_q;
    if (bus.i_clear) begin
      glitch_d = '0;
    end else if (w_abort && (glitch_q != C_GMAX)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  // Output decode, from registered state only.
  always_comb begin
    bus.o_level        = level_q;
    bus.o_rise         = rise_q;
    bus.o_fall         = fall_q;
    bus.o_busy         = (state_q == S_CANDIDATE);
    bus.o_glitch_count = glitch_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_edge_detect
// Description : Self-checking bench. Three debouncer instances run in
//               parallel (STABLE_CYCLES 16/4/1). Every cycle a behavioural
//               model of each instance predicts the outputs after the next
//               edge; predictions are queued and compared once the edge has
//               passed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sig  [3];
  logic clr  [3];
  logic rstn [3];

  logic       o_lvl  [3];
  logic       o_rise [3];
  logic       o_fall [3];
  logic       o_busy [3];
  logic [7:0] o_gc   [3];

  int c_stb  [3] = '{16, 4, 1};
  int c_gmax [3] = '{255, 3, 255};

  debounce_edge_detect_if #(.GLITCH_W(8)) if_a ();
  debounce_edge_detect_if #(.GLITCH_W(2)) if_b ();
  debounce_edge_detect_if #(.GLITCH_W(8)) if_c ();

  assign if_a.i_signal = sig[0];
  assign if_a.i_clear  = clr[0];
  assign if_b.i_signal = sig[1];
  assign if_b.i_clear  = clr[1];
  assign if_c.i_signal = sig[2];
  assign if_c.i_clear  = clr[2];

  assign o_lvl[0]  = if_a.o_level;
  assign o_rise[0] = if_a.o_rise;
  assign o_fall[0] = if_a.o_fall;
  assign o_busy[0] = if_a.o_busy;
  assign o_gc[0]   = if_a.o_glitch_count;
  assign o_lvl[1]  = if_b.o_level;
  assign o_rise[1] = if_b.o_rise;
  assign o_fall[1] = if_b.o_fall;
  assign o_busy[1] = if_b.o_busy;
  assign o_gc[1]   = {6'd0, if_b.o_glitch_count};
  assign o_lvl[2]  = if_c.o_level;
  assign o_rise[2] = if_c.o_rise;
  assign o_fall[2] = if_c.o_fall;
  assign o_busy[2] = if_c.o_busy;
  assign o_gc[2]   = if_c.o_glitch_count;

  debounce_edge_detect #(.STABLE_CYCLES(16), .RESET_VALUE(1'b0), .GLITCH_W(8)) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rstn[0]),
    .bus     (if_a)
  );

  debounce_edge_detect #(.STABLE_CYCLES(4), .RESET_VALUE(1'b0), .GLITCH_W(2)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rstn[1]),
    .bus     (if_b)
  );

  debounce_edge_detect #(.STABLE_CYCLES(1), .RESET_VALUE(1'b0), .GLITCH_W(8)) u_dut_c (
    .i_clk   (clk),
    .i_rst_n (rstn[2]),
    .bus     (if_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Behavioural model: m_run counts consecutive samples differing from the
  // debounced level; STABLE_CYCLES of them accept the new value.
  int m_lvl  [3];
  int m_run  [3];
  int m_gc   [3];
  int m_rise [3];
  int m_fall [3];
  int m_busy [3];

  typedef struct {
    int id;
    int lvl;
    int rise;
    int fall;
    int busy;
    int gc;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_edge(input int i);
    bit abort;
    abort = 1'b0;
    if (!rstn[i]) begin
      m_lvl[i]  = 0;
      m_run[i]  = 0;
      m_gc[i]   = 0;
      m_rise[i] = 0;
      m_fall[i] = 0;
      m_busy[i] = 0;
    end else begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (int'(sig[i]) != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] >= c_stb[i]) begin
          m_lvl[i]  = int'(sig[i]);
          m_rise[i] = int'(sig[i]);
          m_fall[i] = int'(!sig[i]);
          m_run[i]  = 0;
        end
      end else begin
        abort    = (m_run[i] > 0);
        m_run[i] = 0;
      end
      m_busy[i] = (m_run[i] > 0) ? 1 : 0;
      if (clr[i])
        m_gc[i] = 0;
      else if (abort && m_gc[i] < c_gmax[i])
        m_gc[i]++;
    end
  endtask

  task automatic step();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      model_edge(i);
      e.id   = i;
      e.lvl  = m_lvl[i];
      e.rise = m_rise[i];
      e.fall = m_fall[i];
      e.busy = m_busy[i];
      e.gc   = m_gc[i];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("u%0d.level", e.id), int'(o_lvl[e.id]),  e.lvl);
      check($sformatf("u%0d.rise",  e.id), int'(o_rise[e.id]), e.rise);
      check($sformatf("u%0d.fall",  e.id), int'(o_fall[e.id]), e.fall);
      check($sformatf("u%0d.busy",  e.id), int'(o_busy[e.id]), e.busy);
      check($sformatf("u%0d.gcnt",  e.id), int'(o_gc[e.id]),   e.gc);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      sig[i]  = 1'b0;
      clr[i]  = 1'b0;
      rstn[i] = 1'b0;
    end
    #1;

    // Reset with the input high on instance A.
    sig[0] = 1'b1;
    steps(3);
    check("rst_level", int'(o_lvl[0]), 0);
    check("rst_gcnt",  int'(o_gc[0]),  0);
    sig[0] = 1'b0;
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    steps(2);

    // Glitch: 15 high samples then low.
    sig[0] = 1'b1;
    steps(15);
    sig[0] = 1'b0;
    steps(3);
    check("glitch_level", int'(o_lvl[0]), 0);
    check("glitch_gcnt",  int'(o_gc[0]),  1);

    // Clean rise: o_level shows 1 after the 16th high sample.
    sig[0] = 1'b1;
    steps(15);
    check("rise_pre_level", int'(o_lvl[0]), 0);
    steps(1);
    check("rise_level", int'(o_lvl[0]), 1);
    check("rise_strobe", int'(o_rise[0]), 1);
    steps(4);

    // Fall, then immediate re-rise needing a full new run.
    sig[0] = 1'b0;
    steps(16);
    check("fall_strobe", int'(o_fall[0]), 1);
    sig[0] = 1'b1;
    steps(15);
    check("rerise_pre_level", int'(o_lvl[0]), 0);
    steps(1);
    check("rerise_strobe", int'(o_rise[0]), 1);
    check("rerise_gcnt",   int'(o_gc[0]),   1);
    steps(2);

    // Reset in the middle of a candidate.
    sig[0] = 1'b0;
    steps(10);
    check("midrst_busy_pre", int'(o_busy[0]), 1);
    rstn[0] = 1'b0;
    steps(1);
    rstn[0] = 1'b1;
    check("midrst_level", int'(o_lvl[0]),  0);
    check("midrst_busy",  int'(o_busy[0]), 0);
    check("midrst_gcnt",  int'(o_gc[0]),   0);
    steps(2);

    // Instance B: five glitches saturate a 2-bit counter.
    for (int g = 0; g < 5; g++) begin
      sig[1] = 1'b1;
      steps(2);
      sig[1] = 1'b0;
      steps(1);
    end
    check("sat_gcnt", int'(o_gc[1]), 3);
    sig[1] = 1'b1;
    steps(2);
    sig[1] = 1'b0;
    clr[1] = 1'b1;
    steps(1);
    clr[1] = 1'b0;
    check("clr_abort_gcnt", int'(o_gc[1]), 0);
    steps(2);

    // Instance C: STABLE_CYCLES=1 follows a toggling input one cycle late.
    for (int t = 0; t < 10; t++) begin
      sig[2] = ~sig[2];
      steps(1);
      check("sc1_follow", int'(o_lvl[2]), int'(sig[2]));
    end
    steps(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounce_edge_detect.md
Name: debounce_edge_detect

Overview:
Consumes the output of a two-flop resynchroniser. Debounces the synchronised level by requiring the input to hold a new value for a run of consecutive cycles before accepting it. Generates single-cycle rise and fall strobes on accepted transitions. Keeps a saturating count of rejected glitches for debug readout. Sits between the resync stage and control logic such as button, switch or async-status inputs.

Parameters:
STABLE_CYCLES, 16, consecutive cycles i_signal must differ from o_level before o_level changes; legal range 1..65535.
RESET_VALUE, 1'b0, reset value of o_level; must match the upstream resync RESET_VALUE.
GLITCH_W, 8, width of o_glitch_count.

Ports:
i_clk  input  1  clock; the same domain as the upstream resync output.
i_rst_n  input  1  reset; synchronous, active-low.
i_signal  input  1  synchronised level from the resync stage.
i_clear  input  1  synchronous clear of o_glitch_count.
o_level  output  1  debounced level.
o_rise  output  1  one-cycle strobe on an accepted 0->1 transition.
o_fall  output  1  one-cycle strobe on an accepted 1->0 transition.
o_busy  output  1  high while a candidate transition is being timed.
o_glitch_count  output  GLITCH_W  saturating count of aborted candidates.

Behaviour:
- Reset: one clock and a synchronous, active-low reset. When i_rst_n is sampled low at a rising edge:
  - o_level = RESET_VALUE
  - o_rise = o_fall = o_busy = 0
  - o_glitch_count = 0
  - internal counter = 0; state = STABLE
- Reset asserted mid-candidate discards the candidate. No strobe and no glitch count result.
- Counter width is $clog2(STABLE_CYCLES+1). It never wraps.
- State STABLE:
  - If i_signal == o_level: stay in STABLE, counter = 0.
  - If i_signal != o_level and STABLE_CYCLES == 1: accept the change at this edge.
  - If i_signal != o_level otherwise: go to CANDIDATE, counter = 1.
- State CANDIDATE (o_busy = 1):
  - If i_signal != o_level and counter == STABLE_CYCLES-1: accept the change.
  - If i_signal != o_level otherwise: counter increments.
  - If i_signal == o_level: abort. Return to STABLE, counter = 0, o_glitch_count increments unless already all-ones.
- Accept, all at the same edge: o_level <= i_signal, state <= STABLE, counter <= 0. Also o_rise <= i_signal or o_fall <= !i_signal.
- Strobes are registered and high for exactly one cycle. They coincide with the first cycle o_level shows the new value. Rise and fall are never both high.
- Latency: i_signal first sampled at the new value at edge N gives o_level changing at edge N+STABLE_CYCLES-1, visible the cycle after that edge.
  - STABLE_CYCLES=1 means one registered cycle of delay, with no filtering.
- After an accept, the opposite transition needs a full new STABLE_CYCLES run. There is no hysteresis shortcut.
- o_glitch_count:
  - i_clear has priority over increment. If an abort and i_clear coincide, the result is 0.
  - Saturates at 2^GLITCH_W-1.
- o_busy is registered. It equals (state == CANDIDATE).
- All outputs are registered. There are no combinational paths from input to output.

Test Plan:
- Reset check: STABLE_CYCLES=16, RESET_VALUE=0. Hold i_rst_n low 3 cycles with i_signal=1 -> o_level=0, strobes 0, o_glitch_count=0.
- Clean rise: i_signal 0->1 held 20 cycles -> o_level rises exactly 16 cycles after the first high sample. o_rise is high for 1 cycle aligned with it. o_busy is high for 15 cycles before that.
- Glitch reject: i_signal high for 15 cycles then low -> o_level stays 0, no o_rise, o_glitch_count=1.
- Saturation and clear:
  - GLITCH_W=2, apply 5 glitches -> o_glitch_count=3.
  - Assert i_clear on the same cycle as a 6th abort -> o_glitch_count=0.
- Fall then immediate re-rise: after o_level=1, i_signal low for 16 cycles -> o_fall, then i_signal high at once -> o_rise only after another 16 cycles. No glitch is counted.
- STABLE_CYCLES=1 and mid-candidate reset:
  - With STABLE_CYCLES=1, toggling i_signal every cycle -> o_level follows with 1-cycle delay, alternating o_rise/o_fall every cycle.
  - With STABLE_CYCLES=16, reset asserted at candidate count 10 -> o_level=RESET_VALUE, o_busy=0, o_glitch_count=0.
